run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter RUN_LEN, default 4: consecutive equal samples that constitute a detected run; legal range 2..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 4: width of the run-length counter.
REQ-003 Clock  input  1  the only clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset; takes priority over every other input.
REQ-005 En  input  1  sample enable; w is consumed only on edges where En=1.
REQ-006 w  input  1  serial data sample.
REQ-007 Mode  input  2  detection mask: bit0 enables zero-run reporting, bit1 enables one-run reporting.
REQ-008 z  output  1  masked detection flag: (z0 & Mode[0]) | (z1 & Mode[1]).
REQ-009 z0  output  1  unmasked flag: current run is zeros, length >= RUN_LEN.
REQ-010 z1  output  1  unmasked flag: current run is ones, length >= RUN_LEN.
REQ-011 State  output  2  FSM state encoding: IDLE=00, RUN0=01, RUN1=10; 11 unused.
REQ-012 RunCnt  output  CNT_W  length of the current run, saturating.
REQ-013 HitCnt  output  8  count of masked detections since reset, saturating.

Function
REQ-014 FSM states: IDLE (no sample accepted since reset), RUN0 (last sample 0), RUN1 (last sample 1).
REQ-015 In IDLE, an enabled sample moves the FSM to RUN0 when w=0 or RUN1 when w=1, and sets RunCnt=1.
REQ-016 In RUN0/RUN1, an enabled sample equal to the last sample keeps the state and increments RunCnt, saturating at 2^CNT_W-1.
REQ-017 In RUN0/RUN1, an enabled sample differing from the last sample switches to the other RUN state and sets RunCnt=1.
REQ-018 When En=0, State, RunCnt, z0, z1 and HitCnt hold their values.
REQ-019 z0 and z1 are Moore outputs decoded from the registered State and RunCnt only: z0 = (State==RUN0 && RunCnt>=RUN_LEN), z1 = (State==RUN1 && RunCnt>=RUN_LEN).
REQ-020 Latency: z0/z1 assert on the clock edge that accepts the RUN_LEN-th equal sample and deassert on the edge that accepts the first differing sample.
REQ-021 z is combinational from z0, z1 and Mode; a Mode change takes effect in the same cycle without altering State.
REQ-022 HitCnt increments by 1 on an enabled edge where RunCnt goes from RUN_LEN-1 to RUN_LEN and the polarity of that run is enabled by Mode at that edge.
REQ-023 HitCnt saturates at 255 and does not wrap.
REQ-024 A run that continues past RUN_LEN, including into RunCnt saturation, produces exactly one HitCnt increment.
REQ-025 Unused State encoding 11 returns to IDLE on the next edge, with RunCnt=0 and z0=z1=0.

Reset
REQ-026 With Reset=1 at a rising edge, regardless of En, the block sets State=IDLE, RunCnt=0, z0=z1=0 and HitCnt=0.
REQ-027 Reset asserted mid-run discards the run; the first enabled sample after Reset deasserts starts a new run at RunCnt=1.
REQ-028 While State=IDLE, z=0 for every Mode value.

Verification (RUN_LEN=4, CNT_W=4)
REQ-029 Reset, then Mode=11, En=1, w=0 for 4 edges -> RunCnt=1,2,3,4; z0=z=1 after the 4th edge; HitCnt=1.
REQ-030 w=1,1,1,0 -> RunCnt=1,2,3,1; State=RUN1 then RUN0; z stays 0; HitCnt unchanged.
REQ-031 w=1 for 20 enabled edges -> RunCnt saturates at 15; z1=1 from the 4th edge onward; HitCnt increments exactly once.
REQ-032 w=0 with En pattern 1,0,0,0,0,0,1,1,1 -> z0 asserts only on the edge that accepts the 4th enabled sample.
REQ-033 Mode=01, 4 ones -> z1=1, z=0, HitCnt unchanged; switching Mode to 11 -> z=1 in the same cycle, HitCnt still unchanged.
REQ-034 Reset pulsed with En=1 after 3 zeros -> all outputs 0 on that edge; 4 further zeros are required before z0=1.

Source files
------------

// File: rtl/run_detector.sv
// rtl/run_detector.sv - serial run detector with masked hit reporting
//
// Tracks runs of equal serial samples and flags runs that reach RUN_LEN.
//
// Ports:
//   Clock   in   sole clock, rising edge
//   Reset   in   synchronous active-high reset, dominates all other inputs
//   En      in   sample enable; w is consumed only when En=1
//   w       in   serial data sample
//   Mode    in   [0] report zero runs, [1] report one runs
//   z       out  masked detection flag (combinational from z0/z1/Mode)
//   z0      out  current run is zeros with length >= RUN_LEN
//   z1      out  current run is ones with length >= RUN_LEN
//   State   out  IDLE=00, RUN0=01, RUN1=10
//   RunCnt  out  saturating length of the current run
//   HitCnt  out  saturating count of masked detections since reset

module run_detector #(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             En,
   input  logic             w,
   input  logic [1:0]       Mode,
   output logic             z,
   output logic             z0,
   output logic             z1,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] RunCnt,
   output logic [7:0]       HitCnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN0   = 2'b01,
      RUN1   = 2'b10,
      UNUSED = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_RUN   = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(RUN_LEN - 1);
   localparam logic [7:0]       HIT_MAX   = 8'hFF;

   state_t           state;
   logic [CNT_W-1:0] run_cnt;
   logic [7:0]       hit_cnt;

   // Sample matches the polarity of the run currently being tracked.
   logic same_pol;
   // Mode bit that governs reporting for the current run's polarity.
   logic pol_en;

   assign same_pol = (w == (state == RUN1));
   assign pol_en   = (state == RUN1) ? Mode[1] : Mode[0];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         run_cnt <= '0;
         hit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (En) begin
                  state   <= w ? RUN1 : RUN0;
                  run_cnt <= CNT_ONE;
               end
            end
            RUN0, RUN1: begin
               if (En) begin
                  if (same_pol) begin
                     if (run_cnt != CNT_MAX) begin
                        run_cnt <= run_cnt + CNT_ONE;
                     end
                     // Only the RUN_LEN-1 -> RUN_LEN step counts, so a long
                     // or saturated run is reported once.
                     if (run_cnt == CNT_PRE && pol_en && hit_cnt != HIT_MAX) begin
                        hit_cnt <= hit_cnt + 8'd1;
                     end
                  end else begin
                     state   <= w ? RUN1 : RUN0;
                     run_cnt <= CNT_ONE;
                  end
               end
            end
            default: begin
               // Illegal encoding: recover to IDLE regardless of En.
               state   <= IDLE;
               run_cnt <= '0;
            end
         endcase
      end
   end

   assign z0     = (state == RUN0) && (run_cnt >= CNT_RUN);
   assign z1     = (state == RUN1) && (run_cnt >= CNT_RUN);
   assign z      = (z0 & Mode[0]) | (z1 & Mode[1]);
   assign State  = state;
   assign RunCnt = run_cnt;
   assign HitCnt = hit_cnt;

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - scoreboard bench for run_detector

module tb_run_detector;

   localparam int RUN_LEN = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             En;
   logic             w;
   logic [1:0]       Mode;
   logic             z;
   logic             z0;
   logic             z1;
   logic [1:0]       State;
   logic [CNT_W-1:0] RunCnt;
   logic [7:0]       HitCnt;

   run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .En     (En),
      .w      (w),
      .Mode   (Mode),
      .z      (z),
      .z0     (z0),
      .z1     (z1),
      .State  (State),
      .RunCnt (RunCnt),
      .HitCnt (HitCnt)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int state;
      int cnt;
      int z0;
      int z1;
      int z;
      int hit;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_state = 0;
   int m_cnt   = 0;
   int m_hit   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic exp_t model_outputs(input logic [1:0] m);
      exp_t x;
      x.state = m_state;
      x.cnt   = m_cnt;
      x.z0    = (m_state == 1 && m_cnt >= RUN_LEN) ? 1 : 0;
      x.z1    = (m_state == 2 && m_cnt >= RUN_LEN) ? 1 : 0;
      x.z     = ((x.z0 == 1 && m[0]) || (x.z1 == 1 && m[1])) ? 1 : 0;
      x.hit   = m_hit;
      return x;
   endfunction

   task automatic model_edge(input logic r, input logic e, input logic d, input logic [1:0] m);
      int pol;
      if (r) begin
         m_state = 0; m_cnt = 0; m_hit = 0;
      end else if (e) begin
         if (m_state == 0) begin
            m_state = d ? 2 : 1; m_cnt = 1;
         end else if ((m_state == 2) == d) begin
            pol = (m_state == 2) ? m[1] : m[0];
            if (m_cnt == RUN_LEN - 1 && pol == 1 && m_hit < 255) m_hit++;
            if (m_cnt < CNT_SAT) m_cnt++;
         end else begin
            m_state = d ? 2 : 1; m_cnt = 1;
         end
      end
   endtask

   task automatic compare_outputs(input string tag, input exp_t x);
      check({tag, ".state"}, 32'(State),  32'(x.state));
      check({tag, ".cnt"},   32'(RunCnt), 32'(x.cnt));
      check({tag, ".z0"},    32'(z0),     32'(x.z0));
      check({tag, ".z1"},    32'(z1),     32'(x.z1));
      check({tag, ".z"},     32'(z),      32'(x.z));
      check({tag, ".hit"},   32'(HitCnt), 32'(x.hit));
   endtask

   // Drive one edge: predict, push, then pop and compare after the edge.
   task automatic step(input logic r, input logic e, input logic d, input logic [1:0] m);
      exp_t x;
      @(negedge Clock);
      Reset = r; En = e; w = d; Mode = m;
      model_edge(r, e, d, m);
      sb_q.push_back(model_outputs(m));
      @(posedge Clock);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         x = sb_q.pop_front();
         compare_outputs("edge", x);
      end
   endtask

   // Change Mode between edges and confirm z follows without a clock.
   task automatic set_mode(input logic [1:0] m);
      exp_t x;
      @(negedge Clock);
      Mode = m;
      #1;
      x = model_outputs(m);
      compare_outputs("mode", x);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] en_pat [9];
      logic [1:0] rm;
      Reset = 1'b1; En = 1'b0; w = 1'b0; Mode = 2'b11;

      // Reset state
      step(1'b1, 1'b1, 1'b1, 2'b11);
      check("rst.state", 32'(State), 32'd0);
      check("rst.hit",   32'(HitCnt), 32'd0);

      // IDLE keeps z low for every Mode
      for (int i = 0; i < 4; i++) set_mode(2'(i));

      // Four zeros reach a zero-run hit
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 2'b11);
         check("zero_run.cnt", 32'(RunCnt), 32'(i));
      end
      check("zero_run.z", 32'(z), 32'd1);
      check("zero_run.hit", 32'(HitCnt), 32'd1);

      // 1,1,1,0: no hit, state flips back to RUN0
      step(1'b0, 1'b1, 1'b1, 2'b11);
      step(1'b0, 1'b1, 1'b1, 2'b11);
      step(1'b0, 1'b1, 1'b1, 2'b11);
      check("short1.cnt", 32'(RunCnt), 32'd3);
      check("short1.state", 32'(State), 32'd2);
      step(1'b0, 1'b1, 1'b0, 2'b11);
      check("short1.back", 32'(State), 32'd1);
      check("short1.hit", 32'(HitCnt), 32'd1);

      // Twenty ones: saturation with a single hit
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 2'b11);
         check("long1.z1", 32'(z1), (i >= 4) ? 32'd1 : 32'd0);
      end
      check("long1.sat", 32'(RunCnt), 32'd15);
      check("long1.hit", 32'(HitCnt), 32'd2);

      // Sparse enables: z0 only on the 4th accepted sample
      step(1'b1, 1'b0, 1'b0, 2'b11);
      en_pat = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      for (int i = 0; i < 9; i++) begin
         step(1'b0, en_pat[i][0], 1'b0, 2'b11);
         check("sparse.z0", 32'(z0), (i == 8) ? 32'd1 : 32'd0);
      end

      // Masked one-run, then unmask without a clock edge
      step(1'b1, 1'b0, 1'b0, 2'b01);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 2'b01);
      check("mask.z1", 32'(z1), 32'd1);
      check("mask.z", 32'(z), 32'd0);
      check("mask.hit", 32'(HitCnt), 32'd0);
      set_mode(2'b11);
      check("unmask.z", 32'(z), 32'd1);
      check("unmask.hit", 32'(HitCnt), 32'd0);

      // Reset mid-run discards progress
      step(1'b1, 1'b0, 1'b0, 2'b11);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b11);
      step(1'b1, 1'b1, 1'b0, 2'b11);
      check("midrst.cnt", 32'(RunCnt), 32'd0);
      check("midrst.state", 32'(State), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 2'b11);
         check("midrst.z0", 32'(z0), (i == 4) ? 32'd1 : 32'd0);
      end

      // HitCnt saturation at 255
      step(1'b1, 1'b0, 1'b0, 2'b11);
      for (int r = 0; r < 260; r++) begin
         for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'b11);
         step(1'b0, 1'b1, 1'b1, 2'b11);
      end
      check("hit.sat", 32'(HitCnt), 32'd255);

      // Random traffic checked against the model
      step(1'b1, 1'b0, 1'b0, 2'b11);
      for (int i = 0; i < 400; i++) begin
         rm = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0) ? ~w : w, rm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
